// File: rtl/data_table_ram_arb_pkg.sv
// Shared definitions for the data-table RAM arbiter: engine count, engine slots, lock FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hash_table;

  localparam int DT_REQ_CNT = 4;

  // Fixed engine slots on the arbiter request vectors.
  localparam int INIT_ENG   = 0;
  localparam int SEARCH_ENG = 1;
  localparam int INSERT_ENG = 2;
  localparam int DELETE_ENG = 3;

  typedef enum logic {
    DT_UNLOCKED = 1'b0,
    DT_LOCKED   = 1'b1
  } dt_lock_state_t;

endpackage

// File: rtl/data_table_ram_arb_rr_arbiter.sv
// Round-robin pick: first masked requester at/after ptr_i, wrapping, plus the pointer after it.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the candidate is actually granted.
// Ports: req_i/mask_i request and eligibility vectors, ptr_i current rr pointer,
//        gnt_o one-hot candidate, idx_o its index, ptr_nxt_o = idx_o+1 mod REQ_CNT, vld_o any candidate.
module rr_arbiter #(
  parameter int REQ_CNT = 4,
  localparam int PTR_W  = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1
) (
  input  logic [REQ_CNT-1:0] req_i,
  input  logic [REQ_CNT-1:0] mask_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [REQ_CNT-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic [PTR_W-1:0]   ptr_nxt_o,
  output logic               vld_o
);

  logic [REQ_CNT-1:0] eff_req;
  assign eff_req = req_i & mask_i;

  // Scan from farthest to nearest so the requester closest to ptr_i wins.
  always_comb begin
    int idx;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    idx   = 0;
    for (int k = REQ_CNT - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= REQ_CNT) idx = idx - REQ_CNT;
      if (eff_req[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        idx_o      = PTR_W'(idx);
        vld_o      = 1'b1;
      end
    end
  end

  assign ptr_nxt_o = (int'(idx_o) == REQ_CNT - 1) ? '0 : idx_o + 1'b1;

endmodule

// File: rtl/data_table_ram_arb.sv
// Shares one data-table RAM (read port A, write port B) among REQ_CNT engines with rr grants and a port lock.
// Latency: grants combinational; read data/valid return RAM_LATENCY cycles after the grant cycle.
// Backpressure: requests held until granted; read withheld on same-cycle write-address hit; returns unthrottled.
// Ports: rd_req/rd_addr/rd_gnt, wr_req/wr_addr/wr_data/wr_gnt per engine; lock_i/lock_owner_o port lock;
//        rd_data_o/rd_data_val_o tagged return; ram_* drive the RAM directly.
module data_table_ram_arb
  import hash_table::*;
#(
  parameter int REQ_CNT     = DT_REQ_CNT,
  parameter int A_WIDTH     = 10,
  parameter int D_WIDTH     = 64,
  parameter int RAM_LATENCY = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [REQ_CNT-1:0]         rd_req_i,
  input  logic [REQ_CNT*A_WIDTH-1:0] rd_addr_i,
  output logic [REQ_CNT-1:0]         rd_gnt_o,
  output logic [D_WIDTH-1:0]         rd_data_o,
  output logic [REQ_CNT-1:0]         rd_data_val_o,
  input  logic [REQ_CNT-1:0]         wr_req_i,
  input  logic [REQ_CNT*A_WIDTH-1:0] wr_addr_i,
  input  logic [REQ_CNT*D_WIDTH-1:0] wr_data_i,
  output logic [REQ_CNT-1:0]         wr_gnt_o,
  input  logic [REQ_CNT-1:0]         lock_i,
  output logic [REQ_CNT-1:0]         lock_owner_o,
  output logic [A_WIDTH-1:0]         ram_rd_addr_o,
  input  logic [D_WIDTH-1:0]         ram_rd_data_i,
  output logic [A_WIDTH-1:0]         ram_wr_addr_o,
  output logic [D_WIDTH-1:0]         ram_wr_data_o,
  output logic                       ram_wr_en_o
);

  localparam int PTR_W = $clog2(REQ_CNT);

  // run_q keeps grants off while reset is held and for the release edge itself.
  logic                 run_q;
  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
  logic [A_WIDTH-1:0]   rd_addr_q;
  logic [REQ_CNT-1:0]   tag_q [RAM_LATENCY];
  dt_lock_state_t       lock_state_q;
  logic [REQ_CNT-1:0]   lock_owner_q;

  logic [REQ_CNT-1:0]   lock_win, gnt_mask;
  logic [REQ_CNT-1:0]   rd_cand, wr_cand;
  logic [PTR_W-1:0]     rd_idx, wr_idx, rd_ptr_nxt, wr_ptr_nxt;
  logic                 rd_vld, wr_vld, rd_collide, rd_go;
  logic [A_WIDTH-1:0]   rd_sel_addr, wr_sel_addr;
  logic [D_WIDTH-1:0]   wr_sel_data;

  // Simultaneous lock requests resolve in read rr order.
  always_comb begin
    int idx;
    lock_win = '0;
    idx      = 0;
    for (int k = REQ_CNT - 1; k >= 0; k--) begin
      idx = int'(rd_ptr_q) + k;
      if (idx >= REQ_CNT) idx = idx - REQ_CNT;
      if (lock_i[idx]) begin
        lock_win      = '0;
        lock_win[idx] = 1'b1;
      end
    end
  end

  // The acquire cycle already restricts grants to the incoming owner.
  always_comb begin
    gnt_mask = '0;
    if (run_q) begin
      if (lock_state_q == DT_LOCKED) gnt_mask = lock_owner_q;
      else if (|lock_i)              gnt_mask = lock_win;
      else                           gnt_mask = '1;
    end
  end

  rr_arbiter #(.REQ_CNT(REQ_CNT)) u_rd_arb (
    .req_i(rd_req_i), .mask_i(gnt_mask), .ptr_i(rd_ptr_q),
    .gnt_o(rd_cand), .idx_o(rd_idx), .ptr_nxt_o(rd_ptr_nxt), .vld_o(rd_vld)
  );

  rr_arbiter #(.REQ_CNT(REQ_CNT)) u_wr_arb (
    .req_i(wr_req_i), .mask_i(gnt_mask), .ptr_i(wr_ptr_q),
    .gnt_o(wr_cand), .idx_o(wr_idx), .ptr_nxt_o(wr_ptr_nxt), .vld_o(wr_vld)
  );

  assign rd_sel_addr = rd_addr_i[int'(rd_idx)*A_WIDTH +: A_WIDTH];
  assign wr_sel_addr = wr_addr_i[int'(wr_idx)*A_WIDTH +: A_WIDTH];
  assign wr_sel_data = wr_data_i[int'(wr_idx)*D_WIDTH +: D_WIDTH];

  assign wr_gnt_o      = wr_cand;
  assign ram_wr_en_o   = wr_vld;
  assign ram_wr_addr_o = wr_vld ? wr_sel_addr : '0;
  assign ram_wr_data_o = wr_vld ? wr_sel_data : '0;

  // Reading the word being written this cycle would return stale data; retry next cycle instead.
  assign rd_collide    = rd_vld && ram_wr_en_o && (rd_sel_addr == ram_wr_addr_o);
  assign rd_go         = rd_vld && !rd_collide;
  assign rd_gnt_o      = rd_go ? rd_cand : '0;
  assign ram_rd_addr_o = rd_go ? rd_sel_addr : rd_addr_q;

  assign rd_data_o     = ram_rd_data_i;
  assign rd_data_val_o = tag_q[RAM_LATENCY-1];
  assign lock_owner_o  = lock_owner_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q     <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_addr_q <= '0;
      for (int s = 0; s < RAM_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      run_q <= 1'b1;
      if (rd_go) begin
        rd_ptr_q  <= rd_ptr_nxt;
        rd_addr_q <= rd_sel_addr;
      end
      if (wr_vld) wr_ptr_q <= wr_ptr_nxt;
      tag_q[0] <= rd_gnt_o;
      for (int s = 1; s < RAM_LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // Owner releases by dropping its lock_i; the release takes effect the following cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_state_q <= DT_UNLOCKED;
      lock_owner_q <= '0;
    end else begin
      case (lock_state_q)
        DT_UNLOCKED: begin
          if (run_q && (|lock_i)) begin
            lock_state_q <= DT_LOCKED;
            lock_owner_q <= lock_win;
          end
        end
        DT_LOCKED: begin
          if (!(|(lock_i & lock_owner_q))) begin
            lock_state_q <= DT_UNLOCKED;
            lock_owner_q <= '0;
          end
        end
        default: begin
          lock_state_q <= DT_UNLOCKED;
          lock_owner_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_table_ram_arb.sv
// Directed bench for data_table_ram_arb with a 2-cycle registered-output RAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_data_table_ram_arb;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    rd_req = '0;
  logic [N*AW-1:0] rd_addr = '0;
  logic [N-1:0]    rd_gnt;
  logic [DW-1:0]   rd_data;
  logic [N-1:0]    rd_val;
  logic [N-1:0]    wr_req = '0;
  logic [N*AW-1:0] wr_addr = '0;
  logic [N*DW-1:0] wr_data = '0;
  logic [N-1:0]    wr_gnt;
  logic [N-1:0]    lock = '0;
  logic [N-1:0]    owner;
  logic [AW-1:0]   ram_rd_addr;
  logic [DW-1:0]   ram_rd_data;
  logic [AW-1:0]   ram_wr_addr;
  logic [DW-1:0]   ram_wr_data;
  logic            ram_wr_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_table_ram_arb #(.REQ_CNT(N), .A_WIDTH(AW), .D_WIDTH(DW), .RAM_LATENCY(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rd_data_o(rd_data), .rd_data_val_o(rd_val),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
    .lock_i(lock), .lock_owner_o(owner),
    .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data),
    .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data), .ram_wr_en_o(ram_wr_en)
  );

  // RAM model: word i preloaded with 0xD000+i; address sampled on the edge, data out two edges later.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rd_p1 = '0, rd_p2 = '0;
  assign ram_rd_data = rd_p2;

  initial for (int i = 0; i < 1024; i++) mem[i] = 64'hD000 + 64'(i);

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    rd_p1 <= mem[ram_rd_addr];
    rd_p2 <= rd_p1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_rd(input int e, input logic [AW-1:0] a);
    rd_addr[e*AW +: AW] = a;
  endtask

  task automatic set_wr(input int e, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr[e*AW +: AW] = a;
    wr_data[e*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rd_req = '0; wr_req = '0; lock = '0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with every request high: nothing granted until after release.
    @(negedge clk);
    rst_n = 1'b0;
    rd_req = '1; wr_req = '1;
    for (int e = 0; e < N; e++) begin
      set_rd(e, AW'(10'h100 + e));
      set_wr(e, AW'(10'h200 + e), 64'h1000 + 64'(e));
    end
    #1;
    chk("rst_rd_gnt", 64'(rd_gnt), 64'h0);
    chk("rst_wr_gnt", 64'(wr_gnt), 64'h0);
    chk("rst_val", 64'(rd_val), 64'h0);
    chk("rst_owner", 64'(owner), 64'h0);
    chk("rst_wr_en", 64'(ram_wr_en), 64'h0);
    chk("rst_rd_addr", 64'(ram_rd_addr), 64'h0);
    chk("rst_wr_addr", 64'(ram_wr_addr), 64'h0);
    @(negedge clk);
    #1;
    chk("rst_hold_rd_gnt", 64'(rd_gnt), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rel_rd_gnt", 64'(rd_gnt), 64'h1);
    chk("rel_wr_gnt", 64'(wr_gnt), 64'h1);
    chk("rel_wr_addr", 64'(ram_wr_addr), 64'h200);

    // Round-robin fairness with all four readers, data tagged back two cycles later.
    do_reset();
    for (int e = 0; e < N; e++) set_rd(e, AW'(10'h10 + e));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rd_req = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) begin
        chk("rr_gnt", 64'(rd_gnt), 64'h1 << (c % 4));
        chk("rr_addr", 64'(ram_rd_addr), 64'h10 + 64'(c % 4));
      end else begin
        chk("rr_gnt_idle", 64'(rd_gnt), 64'h0);
      end
      if (c >= 2) begin
        chk("rr_val", 64'(rd_val), 64'h1 << ((c - 2) % 4));
        chk("rr_dat", rd_data, 64'hD010 + 64'((c - 2) % 4));
      end else begin
        chk("rr_val_early", 64'(rd_val), 64'h0);
      end
    end

    // Read/write address collision: read held one cycle, returns freshly written data.
    do_reset();
    @(negedge clk);
    wr_req = 4'b0010; set_wr(1, 10'h055, 64'hA5);
    rd_req = 4'b0100; set_rd(2, 10'h055);
    #1;
    chk("col_wr_gnt", 64'(wr_gnt), 64'h2);
    chk("col_wr_en", 64'(ram_wr_en), 64'h1);
    chk("col_rd_gnt", 64'(rd_gnt), 64'h0);
    @(negedge clk);
    wr_req = '0;
    #1;
    chk("col_retry_gnt", 64'(rd_gnt), 64'h4);
    chk("col_retry_addr", 64'(ram_rd_addr), 64'h55);
    @(negedge clk);
    rd_req = '0;
    #1;
    chk("col_val_wait", 64'(rd_val), 64'h0);
    @(negedge clk);
    #1;
    chk("col_val", 64'(rd_val), 64'h4);
    chk("col_dat", rd_data, 64'hA5);

    // Engine 2 locks for a read/read/write chain while engine 0 keeps requesting.
    do_reset();
    set_rd(0, 10'h030); set_rd(2, 10'h020);
    set_wr(0, 10'h041, 64'h41); set_wr(2, 10'h040, 64'h77);
    @(negedge clk);
    lock = 4'b0100; rd_req = 4'b0101; wr_req = 4'b0001;
    #1;
    chk("lk0_rd_gnt", 64'(rd_gnt), 64'h4);
    chk("lk0_wr_gnt", 64'(wr_gnt), 64'h0);
    chk("lk0_owner", 64'(owner), 64'h0);
    @(negedge clk);
    #1;
    chk("lk1_rd_gnt", 64'(rd_gnt), 64'h4);
    chk("lk1_owner", 64'(owner), 64'h4);
    @(negedge clk);
    rd_req = 4'b0001; wr_req = 4'b0101;
    #1;
    chk("lk2_rd_gnt", 64'(rd_gnt), 64'h0);
    chk("lk2_wr_gnt", 64'(wr_gnt), 64'h4);
    chk("lk2_owner", 64'(owner), 64'h4);
    @(negedge clk);
    lock = '0; rd_req = 4'b0001; wr_req = 4'b0001;
    #1;
    chk("lk3_rd_gnt", 64'(rd_gnt), 64'h0);
    chk("lk3_wr_gnt", 64'(wr_gnt), 64'h0);
    chk("lk3_owner", 64'(owner), 64'h4);
    @(negedge clk);
    #1;
    chk("lk4_rd_gnt", 64'(rd_gnt), 64'h1);
    chk("lk4_wr_gnt", 64'(wr_gnt), 64'h1);
    chk("lk4_owner", 64'(owner), 64'h0);

    // Simultaneous lock from engines 1 and 3 with rd pointer at 2: engine 3 wins first.
    do_reset();
    set_rd(1, 10'h011);
    @(negedge clk);
    rd_req = 4'b0010;
    #1;
    chk("sl0_rd_gnt", 64'(rd_gnt), 64'h2);
    @(negedge clk);
    lock = 4'b1010;
    #1;
    chk("sl1_rd_gnt", 64'(rd_gnt), 64'h0);
    chk("sl1_owner", 64'(owner), 64'h0);
    @(negedge clk);
    #1;
    chk("sl2_owner", 64'(owner), 64'h8);
    chk("sl2_rd_gnt", 64'(rd_gnt), 64'h0);
    @(negedge clk);
    lock = 4'b0010;
    #1;
    chk("sl3_owner", 64'(owner), 64'h8);
    chk("sl3_rd_gnt", 64'(rd_gnt), 64'h0);
    @(negedge clk);
    #1;
    chk("sl4_rd_gnt", 64'(rd_gnt), 64'h2);
    chk("sl4_owner", 64'(owner), 64'h0);
    @(negedge clk);
    #1;
    chk("sl5_owner", 64'(owner), 64'h2);
    chk("sl5_rd_gnt", 64'(rd_gnt), 64'h2);

    // Reset right after a read grant: the in-flight return must never surface.
    do_reset();
    set_rd(0, 10'h010);
    @(negedge clk);
    rd_req = 4'b0001;
    #1;
    chk("mr_gnt", 64'(rd_gnt), 64'h1);
    @(negedge clk);
    rd_req = '0; rst_n = 1'b0;
    #1;
    chk("mr_val_rst", 64'(rd_val), 64'h0);
    chk("mr_owner_rst", 64'(owner), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_val_rel", 64'(rd_val), 64'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("mr_val_after", 64'(rd_val), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
